sysid_check_master: RTL
=======================

Name: sysid_check_master

Overview:
- Avalon-MM read initiator that interrogates a system-ID responder on the LT24 Qsys fabric.
- It reads the ID word at word address 0 and the build timestamp at word address 1, then compares both against expected parameters.
- Boot or diagnostic logic uses it to confirm that the loaded FPGA image matches the software build before the LT24 display path is enabled.
- It supports waitrequest back-pressure, variable read latency via readdatavalid, and a per-read timeout.

Parameters:
- EXPECTED_ID, 32'd0, value the ID word must equal.
- EXPECTED_TS, 32'd1403181268, value the timestamp word must equal.
- ADDR_W, 1, width of avm_address (word addressing).
- TIMEOUT_CYCLES, 255, maximum cycles per read from request assertion to readdatavalid; legal range 2..65535.
- MAX_RETRIES, 2, retries per read when SYSID_CHECK_RETRY_EN is defined; legal range 0..3.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a check.
- avm_address  out  ADDR_W  word address (0 = ID, 1 = timestamp).
- avm_read  out  1  read request.
- avm_waitrequest  in  1  responder stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  readdata qualifier.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.
- busy  out  1  check in progress.
- done  out  1  check finished; held until the next accepted start.
- id_ok  out  1  id_value == EXPECTED_ID; valid while done=1.
- ts_ok  out  1  ts_value == EXPECTED_TS; valid while done=1.
- timeout  out  1  a read exceeded TIMEOUT_CYCLES; valid while done=1.
- retry_count  out  2  total retries used; this port exists only with SYSID_CHECK_RETRY_EN.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All outputs are registered.
  - Reset values: every output is 0, including avm_read, avm_address, id_value, ts_value and retry_count. State returns to IDLE.
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
- Start handling:
  - In IDLE or DONE, start=1 at edge N clears done, id_ok, ts_ok, timeout and retry_count.
  - At N+1: busy=1, state=ID_REQ, avm_read=1, avm_address=0.
  - start while busy is ignored.
- REQ states:
  - avm_read and avm_address are held stable while avm_waitrequest=1.
  - At the first edge with avm_waitrequest=0 the request is accepted: next cycle avm_read=0 and state moves to the matching WAIT state.
- WAIT states:
  - avm_readdatavalid arrives at least 1 cycle after acceptance.
  - On the edge where it is seen in ID_WAIT: avm_readdata goes to id_value; next cycle is TS_REQ with avm_read=1 and avm_address=1.
  - Same edge in TS_WAIT: avm_readdata goes to ts_value; next cycle is DONE.
  - On entering DONE: busy=0, done=1, and id_ok/ts_ok are registered from the comparisons in the same transition.
- Stray readdatavalid: ignored in IDLE, REQ and DONE states.
- Timeout:
  - A 16-bit counter clears on entry to each REQ state and increments every cycle in REQ and WAIT.
  - When the counter reaches TIMEOUT_CYCLES, the read is abandoned: avm_read=0 next cycle (a deliberate fault-path Avalon violation), state=DONE, timeout=1, id_ok=0, ts_ok=0.
  - A read that timed out leaves its captured value unchanged.
- Late data: readdatavalid arriving after a timeout is ignored.
- Simultaneous events: readdatavalid in the same cycle the counter reaches TIMEOUT_CYCLES counts as success, not timeout.
- Reset mid-operation: avm_read goes to 0 at the reset edge; no partial result is reported.
- Minimum latency with zero-wait, 1-cycle-latency responder: start at N -> done=1 at N+5.

Optional Feature:
- SYSID_CHECK_RETRY_EN defined:
  - On timeout, if fewer than MAX_RETRIES retries have been used for the current read, return to that read's REQ state, increment retry_count (saturating at 3) and restart the counter. The timeout output is not set.
  - timeout=1 only after the retries are exhausted.
  - retry_count remains readable in DONE.
- SYSID_CHECK_RETRY_EN undefined: no retry logic, no retry_count port; the first timeout ends the check.

Test Plan:
- Zero-wait responder with 1-cycle latency returning 0 at address 0 and 1403181268 at address 1; start -> done at N+5, id_ok=1, ts_ok=1, timeout=0, each avm_read high exactly 1 cycle.
- waitrequest held 3 cycles on each read, readdatavalid 4 cycles after acceptance; responder returns ts 0x12345678 -> address stable during stall, id_ok=1, ts_ok=0, ts_value=0x12345678.
- Responder never asserts readdatavalid for the ID read, TIMEOUT_CYCLES=10, macro off -> done 11 cycles after ID_REQ entry, timeout=1, id_ok=ts_ok=0; a stray late readdatavalid leaves id_value=0.
- Macro on, MAX_RETRIES=2, first ID read times out and the second succeeds -> retry_count=1, timeout=0, id_ok=1.
- reset asserted while in TS_WAIT -> next cycle all outputs 0 and state IDLE; start pulsed while busy has no effect; a fresh start completes normally.

Source files
------------

// File: rtl/sysid_check_master.sv
// Avalon-MM read initiator: fetches system-ID word (addr 0) and build timestamp (addr 1)
// and compares them with expected values. Define SYSID_CHECK_RETRY_EN for per-read retries.
module sysid_check_master #(
  parameter logic [31:0]  EXPECTED_ID    = 32'd0,
  parameter logic [31:0]  EXPECTED_TS    = 32'd1403181268,
  parameter int unsigned  ADDR_W         = 1,
  parameter int unsigned  TIMEOUT_CYCLES = 255,
  parameter int unsigned  MAX_RETRIES    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout
`ifdef SYSID_CHECK_RETRY_EN
  ,
  output logic [1:0]        retry_count
`endif
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned RC_W  = 2;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || MAX_RETRIES > 3) begin : g_bad_params
    $error("sysid_check_master: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               read_q, read_d;
  logic [31:0]        id_q, id_d, ts_q, ts_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, to_q, to_d;
  logic               expire, is_id, cnt_hit;
`ifdef SYSID_CHECK_RETRY_EN
  logic [RC_W-1:0]    rtry_q, rtry_d, rcnt_q, rcnt_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      read_q  <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_ok_q <= 1'b0;
      ts_ok_q <= 1'b0;
      to_q    <= 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
      rtry_q  <= '0;
      rcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_ok_q <= id_ok_d;
      ts_ok_q <= ts_ok_d;
      to_q    <= to_d;
`ifdef SYSID_CHECK_RETRY_EN
      rtry_q  <= rtry_d;
      rcnt_q  <= rcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    read_d  = read_q;
    id_d    = id_q;
    ts_d    = ts_q;
    busy_d  = busy_q;
    done_d  = done_q;
    id_ok_d = id_ok_q;
    ts_ok_d = ts_ok_q;
    to_d    = to_q;
`ifdef SYSID_CHECK_RETRY_EN
    rtry_d  = rtry_q;
    rcnt_d  = rcnt_q;
`endif
    expire  = 1'b0;
    is_id   = (state_q == S_ID_REQ) || (state_q == S_ID_WAIT);
    cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    case (state_q)
      // Start is taken in two steps: clear results first, launch the ID read next cycle.
      S_IDLE, S_DONE: begin
        if (pend_q) begin
          state_d = S_ID_REQ;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          read_d  = 1'b1;
          addr_d  = '0;
          cnt_d   = '0;
`ifdef SYSID_CHECK_RETRY_EN
          rtry_d  = '0;
`endif
        end else if (start) begin
          pend_d  = 1'b1;
          done_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          to_d    = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
          rcnt_d  = '0;
`endif
        end
      end
      S_ID_REQ, S_TS_REQ: begin
        if (cnt_hit) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!avm_waitrequest) begin
            read_d  = 1'b0;
            state_d = is_id ? S_ID_WAIT : S_TS_WAIT;
          end
        end
      end
      S_ID_WAIT: begin
        if (avm_readdatavalid) begin
          id_d    = avm_readdata;
          state_d = S_TS_REQ;
          read_d  = 1'b1;
          addr_d  = ADDR_W'(1);
          cnt_d   = '0;
`ifdef SYSID_CHECK_RETRY_EN
          rtry_d  = '0;
`endif
        end else if (cnt_hit) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TS_WAIT: begin
        if (avm_readdatavalid) begin
          ts_d    = avm_readdata;
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          id_ok_d = (id_q == EXPECTED_ID);
          ts_ok_d = (avm_readdata == EXPECTED_TS);
        end else if (cnt_hit) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abandoned read: drop the request even if not yet accepted (fault path).
    if (expire) begin
`ifdef SYSID_CHECK_RETRY_EN
      if (rtry_q < RC_W'(MAX_RETRIES)) begin
        state_d = is_id ? S_ID_REQ : S_TS_REQ;
        read_d  = 1'b1;
        cnt_d   = '0;
        rtry_d  = rtry_q + RC_W'(1);
        if (rcnt_q != '1) rcnt_d = rcnt_q + RC_W'(1);
      end else
`endif
      begin
        state_d = S_DONE;
        read_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        to_d    = 1'b1;
        id_ok_d = 1'b0;
        ts_ok_d = 1'b0;
      end
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = to_q;
`ifdef SYSID_CHECK_RETRY_EN
  assign retry_count = rcnt_q;
`endif

endmodule
